daq_readout_framer: RTL
=======================

// Module: daq_readout_framer
// PURPOSE
//  Drains the 48-bit DAQ/track output FIFO on the read clock and builds framed 19-bit DAQ words
//  for the TMB link. Pops FIFO words and forwards each 19-bit DAQ field. Closes each event with a
//  CRC-22 trailer and a word-count trailer. Sits directly downstream of the output FIFO's read port.
// PARAMETERS
//  FIFO_W    48    FIFO word width
//  DAQ_W     19    output DAQ word width
//  DAQ_LSB   9     LSB of the DAQ field in the FIFO word; field = fifo_dout[DAQ_LSB+18:DAQ_LSB], msb = bit 27
//  EOE_BIT   8     FIFO word bit marking the last word of an event
//  CRC_W     22    CRC width; polynomial x^22+x+1, init 0
//  MAX_WORDS 1023  word-count saturation value
// PORTS
//  clk        in   1   read-side clock (same clock as the FIFO rdclk)
//  rst        in   1   asynchronous, active-high reset
//  fifo_dout  in   48  FIFO read data, valid 1 cycle after fifo_rden
//  fifo_empty in   1   FIFO empty flag
//  fifo_rden  out  1   FIFO pop strobe (combinational)
//  daq_en     in   1   downstream ready; low = stall
//  daq_out    out  19  framed DAQ word (registered)
//  daq_valid  out  1   daq_out qualifier
//  frame_act  out  1   high from first data word through WCNT trailer
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; CRC 0; wcnt 0; ovf 0; skid register empty. Takes effect
//    without a clock edge.
//  - Pop rule:
//    fifo_rden = daq_en & !fifo_empty & !skid_full & (state==IDLE | state==DATA) & !eoe_seen.
//  - Latency: rden at cycle n -> fifo_dout valid at n+1 -> daq_out/daq_valid at n+2.
//    Sustains 1 word/clk while daq_en=1 and the FIFO is non-empty.
//  - Skid register: 1 entry. Captures a word returning from the FIFO while daq_en=0, or while the
//    FSM is in a trailer state. The skid register is drained before any new pop. A word is never
//    dropped or duplicated.
//  - FSM states: IDLE, DATA, CRC0, CRC1, WCNT.
//    - IDLE -> DATA on the first data word emitted.
//    - DATA: emit each popped word. Update CRC over all 19 bits. Increment wcnt.
//    - DATA -> CRC0 after emitting a word with EOE_BIT=1.
//    - CRC0 -> CRC1 -> WCNT -> IDLE, one word per cycle, each only when daq_en=1.
//  - Trailer words (bits 18:16 are the tag):
//    - CRC0 = {3'b001, 5'b0, crc[10:0]}
//    - CRC1 = {3'b010, 5'b0, crc[21:11]}
//    - WCNT = {3'b011, ovf, 5'b0, wcnt[9:0]}
//  - CRC and wcnt cover data words only. Both are cleared on leaving WCNT.
//  - wcnt saturates at MAX_WORDS. ovf is set when a data word arrives with wcnt==MAX_WORDS.
//  - EOE pop-ahead: the rden issued in the cycle the EOE word returns may fetch the next event's
//    first word. That word is held in the skid register. It is emitted as data word 1 of the next
//    frame, after WCNT.
//  - fifo_empty mid-event: daq_valid=0 gap cycles. FSM stays in DATA; CRC and wcnt are unchanged.
//  - daq_en=0: daq_valid=0 and daq_out holds. FSM, CRC and wcnt are frozen. An in-flight FIFO word
//    goes to the skid register.
//  - Reset mid-frame: partial frame is abandoned, no trailer is sent, the skid register is cleared.
//  - IDLE with an empty FIFO: daq_valid=0 and frame_act=0.
// STRUCTURE
//  - Package alct_daq_pkg:
//    - width constants DAQ_W, CRC_W, DAQ_LSB, EOE_BIT
//    - trailer tags TAG_CRC0=3'b001, TAG_CRC1=3'b010, TAG_WCNT=3'b011
//    - CRC polynomial constant
//    - FSM state enum
//  - Sub-module crc22_step: combinational next-CRC from (crc[21:0], data[18:0]). Instantiated once.
//  - Top level holds the FSM, skid register, counters and output register.
// TESTING
//  1. One event: daq words 19'h40001, 19'h40002, 19'h40003 (EOE on last), daq_en=1 ->
//     6 consecutive daq_valid words: the 3 data words, then CRC0, CRC1 and WCNT=19'h30003.
//     CRC matches the reference crc22 model.
//  2. 8-word event; daq_en low for 5 cycles after data word 3 -> fifo_rden=0 during the stall.
//     Output is 8 data words in order, no loss or duplication. Trailer wcnt=8.
//  3. 4-word event; fifo_empty forced high for 3 cycles after word 2 -> 3 daq_valid=0 gap cycles.
//     CRC equals the no-gap case.
//  4. 1030-word event -> WCNT word shows wcnt=1023 and ovf=1. Next event's WCNT shows ovf=0.
//  5. Back-to-back events A(2 words), B(2 words) preloaded -> A data, A trailer, B data, B trailer.
//     B word 1 comes from the skid register, and B's CRC is independent of A.
//  6. rst pulsed asynchronously mid-DATA of a 6-word event -> outputs are 0 before the next clk
//     edge. No trailer is sent. The next event frames with CRC init 0 and wcnt from 1.

Source files
------------

// File: rtl/alct_daq_pkg.sv
// Shared constants, trailer tags and FSM encoding for the DAQ readout framer.
package alct_daq_pkg;

  localparam int FIFO_W    = 48;
  localparam int DAQ_W     = 19;
  localparam int DAQ_LSB   = 9;
  localparam int EOE_BIT   = 8;
  localparam int CRC_W     = 22;
  localparam int WCNT_W    = 10;
  localparam int MAX_WORDS = 1023;

  localparam logic [2:0] TAG_CRC0 = 3'b001;
  localparam logic [2:0] TAG_CRC1 = 3'b010;
  localparam logic [2:0] TAG_WCNT = 3'b011;

  // x^22 + x + 1 with the x^22 term implied
  localparam logic [CRC_W-1:0] CRC_POLY = 22'h000003;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    CRC0,
    CRC1,
    WCNT
  } state_t;

  function automatic logic [DAQ_W-1:0] crc0_word(
    input logic [CRC_W-1:0] crc
  );
    return {TAG_CRC0, 5'b0, crc[10:0]};
  endfunction

  function automatic logic [DAQ_W-1:0] crc1_word(
    input logic [CRC_W-1:0] crc
  );
    return {TAG_CRC1, 5'b0, crc[21:11]};
  endfunction

  function automatic logic [DAQ_W-1:0] wcnt_word(
    input logic              ovf,
    input logic [WCNT_W-1:0] wcnt
  );
    return {TAG_WCNT, ovf, 5'b0, wcnt};
  endfunction

endpackage

// File: rtl/crc22_step.sv
// Next CRC-22 value after shifting in one 19-bit DAQ word, MSB first.
module crc22_step
  import alct_daq_pkg::*;
(
  input  logic [CRC_W-1:0] crc_in,
  input  logic [DAQ_W-1:0] data,
  output logic [CRC_W-1:0] crc_out
);

  logic [CRC_W-1:0] c;
  logic             fb;

  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int i = DAQ_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ data[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/daq_readout_framer.sv
// Drains the DAQ output FIFO and frames 19-bit words with CRC and
// word-count trailers for the TMB link.
module daq_readout_framer
  import alct_daq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [FIFO_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rden,
  input  logic              daq_en,
  output logic [DAQ_W-1:0]  daq_out,
  output logic              daq_valid,
  output logic              frame_act
);

  state_t             state;
  logic               rd_q;
  logic               skid_full;
  logic [DAQ_W-1:0]   skid_data;
  logic               skid_eoe;
  logic               eoe_seen;
  logic [CRC_W-1:0]   crc;
  logic [CRC_W-1:0]   crc_next;
  logic [WCNT_W-1:0]  wcnt;
  logic               ovf;

  logic [DAQ_W-1:0]   in_word;
  logic               in_eoe;
  logic               data_phase;
  logic               src_valid;
  logic [DAQ_W-1:0]   src_word;
  logic               src_eoe;
  logic               emit_data;
  logic               to_skid;
  logic               wcnt_max;
  logic               unused_bits;

  assign in_word = fifo_dout[DAQ_LSB+DAQ_W-1:DAQ_LSB];
  assign in_eoe  = fifo_dout[EOE_BIT];
  assign unused_bits = ^{fifo_dout[FIFO_W-1:DAQ_LSB+DAQ_W],
                         fifo_dout[EOE_BIT-1:0]};

  assign data_phase = (state == IDLE) || (state == DATA);

  // skid always wins; it can never be full while a word returns
  assign src_valid = skid_full | rd_q;
  assign src_word  = skid_full ? skid_data : in_word;
  assign src_eoe   = skid_full ? skid_eoe : in_eoe;
  assign emit_data = data_phase & daq_en & src_valid;
  assign to_skid   = rd_q & ~(emit_data & ~skid_full);
  assign wcnt_max  = (wcnt == WCNT_W'(MAX_WORDS));

  assign fifo_rden = ~rst & daq_en & ~fifo_empty & ~skid_full
                   & data_phase & ~eoe_seen;

  crc22_step u_crc (
    .crc_in  (crc),
    .data    (src_word),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_q      <= 1'b0;
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_eoe  <= 1'b0;
      eoe_seen  <= 1'b0;
      crc       <= '0;
      wcnt      <= '0;
      ovf       <= 1'b0;
      daq_out   <= '0;
      daq_valid <= 1'b0;
      frame_act <= 1'b0;
    end else begin
      rd_q      <= fifo_rden;
      daq_valid <= 1'b0;
      frame_act <= (state != IDLE) | emit_data;

      if (to_skid) begin
        skid_full <= 1'b1;
        skid_data <= in_word;
        skid_eoe  <= in_eoe;
      end else if (emit_data && skid_full) begin
        skid_full <= 1'b0;
      end

      // an event's last word has been fetched: stop popping
      if (rd_q && in_eoe && data_phase) begin
        eoe_seen <= 1'b1;
      end

      unique case (state)
        IDLE, DATA: begin
          if (emit_data) begin
            daq_out   <= src_word;
            daq_valid <= 1'b1;
            crc       <= crc_next;
            if (wcnt_max) begin
              ovf <= 1'b1;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
            state <= src_eoe ? CRC0 : DATA;
          end
        end
        CRC0: begin
          if (daq_en) begin
            daq_out   <= crc0_word(crc);
            daq_valid <= 1'b1;
            state     <= CRC1;
          end
        end
        CRC1: begin
          if (daq_en) begin
            daq_out   <= crc1_word(crc);
            daq_valid <= 1'b1;
            state     <= WCNT;
          end
        end
        WCNT: begin
          if (daq_en) begin
            daq_out   <= wcnt_word(ovf, wcnt);
            daq_valid <= 1'b1;
            state     <= IDLE;
            crc       <= '0;
            wcnt      <= '0;
            ovf       <= 1'b0;
            eoe_seen  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
